tx_pattern_gen: RTL and testbench

//  Parametrised payload pattern generator for the transceiver Tx path; next generation of the free-running Tx counter.

---
 rtl/tx_pattern_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_tx_pattern_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pattern_gen.sv
// rtl/tx_pattern_gen.sv - framed Tx payload pattern generator with gaps and error injection
// Mode 11 is PRBS31 when TX_PATGEN_PRBS_EN is defined, otherwise it aliases incrementing mode.
module tx_pattern_gen #(
  parameter int DATA_W = 32,
  parameter int FLEN_W = 16,
  parameter int GAP_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [FLEN_W-1:0] frame_len_i,
  input  logic [GAP_W-1:0]  gap_i,
  input  logic              err_inject_i,
  input  logic              err_cont_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              sof_o,
  output logic              eof_o,
  output logic [31:0]       frame_cnt_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, GAP = 2'd2} state_t;

  localparam logic [1:0] M_INC  = 2'b00;
  localparam logic [1:0] M_DEC  = 2'b01;
  localparam logic [1:0] M_WALK = 2'b10;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              busy_q, busy_d;
  logic              err_pend_q, err_pend_d;
  logic [1:0]        mode_q, mode_d;
  logic [FLEN_W-1:0] len_q, len_d;
  logic [FLEN_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;

  logic              xfer;
  logic              load;
  logic              load_sof;
  logic [1:0]        ld_mode;
  logic [FLEN_W-1:0] ld_len;
  logic [DATA_W-1:0] ld_pat;

  function automatic logic [1:0] eff_mode(input logic [1:0] m);
`ifdef TX_PATGEN_PRBS_EN
    return m;
`else
    return (m == 2'b11) ? M_INC : m;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] seed(input logic [1:0] m);
    case (m)
      M_DEC:   return '1;
      M_WALK:  return DATA_W'(1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] step(input logic [DATA_W-1:0] p, input logic [1:0] m);
    case (m)
      M_DEC:   return p - DATA_W'(1);
      M_WALK:  return {p[DATA_W-2:0], p[DATA_W-1]};
      default: return p + DATA_W'(1);
    endcase
  endfunction

`ifdef TX_PATGEN_PRBS_EN
  localparam logic [1:0] M_PRBS = 2'b11;

  logic [30:0]       lfsr_q, lfsr_d;
  logic [30:0]       prbs_next;
  logic [DATA_W-1:0] prbs_word;

  // x^31 + x^28 + 1, DATA_W steps per word; first bit out lands in the MSB
  always_comb begin
    prbs_next = (state_q == IDLE) ? '1 : lfsr_q;
    prbs_word = '0;
    for (int i = 0; i < DATA_W; i++) begin
      prbs_next = {prbs_next[29:0], prbs_next[30] ^ prbs_next[27]};
      prbs_word[DATA_W-1-i] = prbs_next[0];
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    data_d      = data_q;
    valid_d     = valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    mode_d      = mode_q;
    len_d       = len_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    frame_cnt_d = frame_cnt_q;
    err_pend_d  = err_pend_q | err_inject_i;
    xfer        = valid_q & ready_i;
    load        = 1'b0;
    load_sof    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          load     = 1'b1;
          load_sof = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (!eof_q) begin
            load = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            if (!start_i) begin
              state_d = IDLE;
              valid_d = 1'b0;
              sof_d   = 1'b0;
              eof_d   = 1'b0;
            end else if (gap_i == '0) begin
              load     = 1'b1;
              load_sof = 1'b1;
            end else begin
              state_d = GAP;
              gap_d   = gap_i;
              valid_d = 1'b0;
              sof_d   = 1'b0;
              eof_d   = 1'b0;
            end
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(1)) begin
          if (start_i) begin
            load     = 1'b1;
            load_sof = 1'b1;
            state_d  = RUN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The first word of a frame is generated under the mode latched for that frame
    ld_mode = load_sof ? eff_mode(mode_i) : mode_q;
    ld_len  = (frame_len_i == '0) ? FLEN_W'(1) : frame_len_i;
    ld_pat  = (state_q == IDLE) ? seed(ld_mode) : step(pat_q, ld_mode);
`ifdef TX_PATGEN_PRBS_EN
    lfsr_d = (state_q == IDLE) ? '1 : lfsr_q;
    if (ld_mode == M_PRBS) begin
      ld_pat = prbs_word;
      if (load) lfsr_d = prbs_next;
    end
`endif

    if (load) begin
      pat_d      = ld_pat;
      data_d     = (err_pend_q | err_inject_i | err_cont_i) ? ~ld_pat : ld_pat;
      err_pend_d = 1'b0;
      valid_d    = 1'b1;
      sof_d      = load_sof;
      if (load_sof) begin
        mode_d = ld_mode;
        len_d  = ld_len;
        idx_d  = '0;
        eof_d  = (ld_len == FLEN_W'(1));
      end else begin
        idx_d = idx_q + FLEN_W'(1);
        eof_d = ((idx_q + FLEN_W'(1)) == (len_q - FLEN_W'(1)));
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_pend_q  <= 1'b0;
      mode_q      <= M_INC;
      len_q       <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      frame_cnt_q <= '0;
`ifdef TX_PATGEN_PRBS_EN
      lfsr_q      <= '1;
`endif
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      err_pend_q  <= err_pend_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef TX_PATGEN_PRBS_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_tx_pattern_gen.sv
// tb/tb_tx_pattern_gen.sv - directed vector bench for tx_pattern_gen
module tb_tx_pattern_gen;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [1:0]  mode_i;
  logic [15:0] frame_len_i;
  logic [7:0]  gap_i;
  logic        err_inject_i;
  logic        err_cont_i;
  logic        ready_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        sof_o;
  logic        eof_o;
  logic [31:0] frame_cnt_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  tx_pattern_gen #(
    .DATA_W(32),
    .FLEN_W(16),
    .GAP_W (8)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .frame_len_i (frame_len_i),
    .gap_i       (gap_i),
    .err_inject_i(err_inject_i),
    .err_cont_i  (err_cont_i),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .sof_o       (sof_o),
    .eof_o       (eof_o),
    .frame_cnt_o (frame_cnt_o),
    .busy_o      (busy_o)
  );

  typedef struct packed {
    logic        start;
    logic [1:0]  mode;
    logic [15:0] flen;
    logic [7:0]  gap;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_sof;
    logic        e_eof;
    logic        e_busy;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(input logic s, input logic [1:0] m, input logic [15:0] fl,
                              input logic [7:0] g, input logic r, input logic v,
                              input logic [31:0] d, input logic so, input logic eo,
                              input logic b);
    vec_t t;
    t.start   = s;
    t.mode    = m;
    t.flen    = fl;
    t.gap     = g;
    t.ready   = r;
    t.e_valid = v;
    t.e_data  = d;
    t.e_sof   = so;
    t.e_eof   = eo;
    t.e_busy  = b;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_word(input string nm, input logic [31:0] d, input logic so, input logic eo);
    chk({nm, "_valid"}, valid_o, 1'b1);
    chk({nm, "_data"}, data_o, d);
    chk({nm, "_sof"}, sof_o, so);
    chk({nm, "_eof"}, eof_o, eo);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_i = 1'b1; start_i = 1'b0; mode_i = 2'b00; frame_len_i = 16'd4; gap_i = 8'd0;
    err_inject_i = 1'b0; err_cont_i = 1'b0; ready_i = 1'b1;

    // back-to-back frames of 4, mid-frame mode/length changes, then ready toggling, then stop
    vecs[0]  = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd0,  1, 0, 1);
    vecs[1]  = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd1,  0, 0, 1);
    vecs[2]  = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd2,  0, 0, 1);
    vecs[3]  = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd3,  0, 1, 1);
    vecs[4]  = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd4,  1, 0, 1);
    vecs[5]  = mk(1, 2'b10, 16'd2, 8'd0, 1, 1, 32'd5,  0, 0, 1);
    vecs[6]  = mk(1, 2'b10, 16'd2, 8'd0, 1, 1, 32'd6,  0, 0, 1);
    vecs[7]  = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd7,  0, 1, 1);
    vecs[8]  = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd8,  1, 0, 1);
    vecs[9]  = mk(1, 2'b00, 16'd4, 8'd0, 0, 1, 32'd8,  1, 0, 1);
    vecs[10] = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd9,  0, 0, 1);
    vecs[11] = mk(1, 2'b00, 16'd4, 8'd0, 0, 1, 32'd9,  0, 0, 1);
    vecs[12] = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd10, 0, 0, 1);
    vecs[13] = mk(1, 2'b00, 16'd4, 8'd0, 0, 1, 32'd10, 0, 0, 1);
    vecs[14] = mk(1, 2'b00, 16'd4, 8'd0, 1, 1, 32'd11, 0, 1, 1);
    vecs[15] = mk(1, 2'b00, 16'd4, 8'd0, 0, 1, 32'd11, 0, 1, 1);
    vecs[16] = mk(0, 2'b00, 16'd4, 8'd0, 1, 0, 32'd0,  0, 0, 0);

    repeat (3) tick();
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_fcnt", frame_cnt_o, 32'd0);
    chk("rst_busy", busy_o, 1'b0);
    reset_i = 1'b0;
    tick();
    chk("idle_valid", valid_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);

    for (int i = 0; i < 17; i++) begin
      start_i = vecs[i].start; mode_i = vecs[i].mode; frame_len_i = vecs[i].flen;
      gap_i = vecs[i].gap; ready_i = vecs[i].ready;
      tick();
      chk($sformatf("v%0d_valid", i), valid_o, vecs[i].e_valid);
      chk($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_data", i), data_o, vecs[i].e_data);
        chk($sformatf("v%0d_sof", i), sof_o, vecs[i].e_sof);
        chk($sformatf("v%0d_eof", i), eof_o, vecs[i].e_eof);
      end
    end
    chk("table_fcnt", frame_cnt_o, 32'd3);

    // error injection: reseeded from IDLE, pulse while stalled on word 5
    start_i = 1'b1; mode_i = 2'b00; frame_len_i = 16'd16; gap_i = 8'd0; ready_i = 1'b1;
    tick();
    chk_word("err_w0", 32'd0, 1'b1, 1'b0);
    repeat (5) tick();
    chk_word("err_w5", 32'd5, 1'b0, 1'b0);
    ready_i = 1'b0; err_inject_i = 1'b1;
    tick();
    err_inject_i = 1'b0;
    chk("err_stall1", data_o, 32'd5);
    tick();
    chk("err_stall2", data_o, 32'd5);
    ready_i = 1'b1;
    tick();
    chk("err_w6_inv", data_o, 32'hFFFF_FFF9);
    tick();
    chk("err_w7", data_o, 32'd7);
    err_cont_i = 1'b1;
    tick();
    chk("cont_w8", data_o, 32'hFFFF_FFF7);
    tick();
    chk("cont_w9", data_o, 32'hFFFF_FFF6);
    err_cont_i = 1'b0;
    tick();
    chk("cont_w10", data_o, 32'd10);
    err_inject_i = 1'b1; err_cont_i = 1'b1;
    tick();
    err_inject_i = 1'b0; err_cont_i = 1'b0;
    chk("both_w11", data_o, 32'hFFFF_FFF4);
    tick();
    chk_word("both_w12", 32'd12, 1'b0, 1'b0);

    // asynchronous reset in the middle of a frame
    reset_i = 1'b1;
    #1;
    chk("arst_valid_now", valid_o, 1'b0);
    tick();
    chk("arst_valid", valid_o, 1'b0);
    chk("arst_data", data_o, 32'd0);
    chk("arst_fcnt", frame_cnt_o, 32'd0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_eof", eof_o, 1'b0);
    reset_i = 1'b0; start_i = 1'b0;
    tick();

    // wrap checks: decr from all-ones, switch to incr across the FFFF_FFFF/0 boundary, back to decr from 0
    start_i = 1'b1; mode_i = 2'b01; frame_len_i = 16'd2;
    tick();
    chk_word("wrap_a", 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    chk_word("wrap_b", 32'hFFFF_FFFE, 1'b0, 1'b1);
    mode_i = 2'b00;
    tick();
    chk_word("wrap_c", 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    chk_word("wrap_d", 32'h0000_0000, 1'b0, 1'b1);
    mode_i = 2'b01; frame_len_i = 16'd0;
    tick();
    chk_word("wrap_e_len0", 32'hFFFF_FFFF, 1'b1, 1'b1);
    start_i = 1'b0;
    tick();
    chk("wrap_idle_valid", valid_o, 1'b0);
    chk("wrap_idle_busy", busy_o, 1'b0);
    chk("wrap_fcnt", frame_cnt_o, 32'd3);

    // start dropped on word 0 of a 2-word frame
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    start_i = 1'b1; mode_i = 2'b00; frame_len_i = 16'd2; gap_i = 8'd3;
    tick();
    chk_word("stop_w0", 32'd0, 1'b1, 1'b0);
    start_i = 1'b0;
    tick();
    chk_word("stop_w1", 32'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stop_idle%0d_valid", i), valid_o, 1'b0);
    end
    chk("stop_busy", busy_o, 1'b0);
    chk("stop_fcnt", frame_cnt_o, 32'd1);

    // inter-frame gap of 3 with start held
    start_i = 1'b1;
    tick();
    chk_word("gap_w0", 32'd0, 1'b1, 1'b0);
    tick();
    chk_word("gap_w1", 32'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("gap%0d_valid", i), valid_o, 1'b0);
      chk($sformatf("gap%0d_busy", i), busy_o, 1'b1);
    end
    tick();
    chk_word("gap_w2", 32'd2, 1'b1, 1'b0);
    start_i = 1'b0;
    tick();
    chk_word("gap_w3", 32'd3, 1'b0, 1'b1);
    tick();
    chk("gap_end_valid", valid_o, 1'b0);
    chk("gap_end_busy", busy_o, 1'b0);
    chk("gap_end_fcnt", frame_cnt_o, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
